alu_flag_stage: RTL and testbench

Registered stage directly downstream of the 32-bit add/sub unit (unit_A). Captures the unit's sum, carry-out and the operands/function code that produced them, then computes the N/Z/C/O flags. Buffers results in a 2-entry FIFO with a valid/ready handshake toward the writeback/branch logic. Also keeps a sticky overflow flag that software clears explicitly.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_flag_calc.sv | 64 ++++++
 rtl/alu_flag_stage.sv | 134 +++++++++++++
 tb/tb_alu_flag_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU flag stage: op encodings, flag bit
// positions and the default datapath width.
package alu_pkg;

  localparam int W_DEFAULT = 32;

  // Function code low bits as decoded by the upstream add/sub unit
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_NEG = 2'b10,
    OP_INC = 2'b11
  } op_e;

  // Bit positions inside the packed {N,Z,C,O} flag nibble
  localparam int FLAG_N    = 3;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_C    = 1;
  localparam int FLAG_O    = 0;
  localparam int NUM_FLAGS = 4;

  // Two's-complement overflow: both effective operands share a sign
  // and the result sign differs from it
  function automatic logic signedOverflow(input logic ea, input logic eb, input logic sMsb);
    return (ea == eb) && (sMsb != ea);
  endfunction

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational N/Z/C/O flag generation from the add/sub unit's operands,
// function code, sum and carry-out.
module alu_flag_calc
  import alu_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [3:0]   i_f,
  input  logic [W-1:0] i_s,
  input  logic         i_c_out,
  output logic         o_n,
  output logic         o_z,
  output logic         o_c,
  output logic         o_o
);

  op_e  w_op;
  logic w_ea;
  logic w_eb;
  logic w_unused;

  assign w_op = op_e'(i_f[1:0]);

  // Only the operand sign bits matter for overflow; f[3:2] is carried
  // through by the stage and never influences the flags
  assign w_unused = ^{i_a[W-2:0], i_b[W-2:0], i_f[3:2]};

  // Recreate the sign bits the adder actually saw: NEG/INC feed a zero
  // in place of a, SUB/NEG feed the inverted b
  always_comb begin
    w_ea = i_a[W-1];
    w_eb = i_b[W-1];
    case (w_op)
      OP_ADD: begin
        w_ea = i_a[W-1];
        w_eb = i_b[W-1];
      end
      OP_SUB: begin
        w_ea = i_a[W-1];
        w_eb = ~i_b[W-1];
      end
      OP_NEG: begin
        w_ea = 1'b0;
        w_eb = ~i_b[W-1];
      end
      OP_INC: begin
        w_ea = 1'b0;
        w_eb = i_b[W-1];
      end
      default: begin
        w_ea = i_a[W-1];
        w_eb = i_b[W-1];
      end
    endcase
  end

  assign o_n = i_s[W-1];
  assign o_z = (i_s == '0);
  assign o_c = i_c_out;
  assign o_o = signedOverflow(w_ea, w_eb, i_s[W-1]);

endmodule

// File: rtl/alu_flag_stage.sv
// Registered stage behind the add/sub unit: computes flags at the input,
// buffers {sum, function code, flags} in a 2-entry FIFO with valid/ready
// handshakes, and keeps a software-cleared sticky overflow bit.
module alu_flag_stage
  import alu_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   f,
  input  logic [W-1:0] s,
  input  logic         c_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_s,
  output logic [3:0]   out_f,
  output logic         out_n,
  output logic         out_z,
  output logic         out_c,
  output logic         out_o,
  output logic         sticky_o,
  input  logic         clr_sticky,
  output logic [1:0]   count
);

  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  typedef struct packed {
    logic [W-1:0]           s;
    logic [3:0]             f;
    logic [NUM_FLAGS-1:0]   flags;
  } entry_t;

  entry_t     r_mem [0:1];
  logic       r_wrPtr;
  logic       r_rdPtr;
  logic [1:0] r_count;
  logic       r_sticky;

  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_o;
  logic       w_push;
  logic       w_pop;
  entry_t     w_newEntry;
  entry_t     w_head;

  alu_flag_calc #(.W(W)) u_calc (
    .i_a     (a),
    .i_b     (b),
    .i_f     (f),
    .i_s     (s),
    .i_c_out (c_out),
    .o_n     (w_n),
    .o_z     (w_z),
    .o_c     (w_c),
    .o_o     (w_o)
  );

  // in_ready depends only on the registered count, so there is no
  // combinational path from out_ready back to the upstream unit
  assign in_ready  = (r_count < FULL_COUNT);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign w_newEntry.s                = s;
  assign w_newEntry.f                = f;
  assign w_newEntry.flags[FLAG_N]    = w_n;
  assign w_newEntry.flags[FLAG_Z]    = w_z;
  assign w_newEntry.flags[FLAG_C]    = w_c;
  assign w_newEntry.flags[FLAG_O]    = w_o;

  // Storage and 1-bit pointers; a push+pop at count=1 writes the other
  // slot and moves the read pointer onto it, so the new entry becomes head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wrPtr  <= 1'b0;
      r_rdPtr  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= w_newEntry;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
    end
  end

  // Occupancy tracking; simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: clear wins over a same-cycle overflowing push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky <= 1'b0;
    end else if (clr_sticky) begin
      r_sticky <= 1'b0;
    end else if (w_push && w_o) begin
      r_sticky <= 1'b1;
    end
  end

  assign w_head   = r_mem[r_rdPtr];
  assign out_s    = w_head.s;
  assign out_f    = w_head.f;
  assign out_n    = w_head.flags[FLAG_N];
  assign out_z    = w_head.flags[FLAG_Z];
  assign out_c    = w_head.flags[FLAG_C];
  assign out_o    = w_head.flags[FLAG_O];
  assign sticky_o = r_sticky;
  assign count    = r_count;

endmodule

// File: tb/tb_alu_flag_stage.sv
// Scoreboard bench for alu_flag_stage: the driver queues the hand-computed
// expected entry when the stage accepts it, and a monitor compares the
// head whenever the stage hands an entry downstream.
module tb_alu_flag_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  f;
  logic [31:0] s;
  logic        c_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_s;
  logic [3:0]  out_f;
  logic        out_n;
  logic        out_z;
  logic        out_c;
  logic        out_o;
  logic        sticky_o;
  logic        clr_sticky;
  logic [1:0]  count;

  typedef struct packed {
    logic [31:0] s;
    logic [3:0]  f;
    logic [3:0]  fl;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  f;
    logic [31:0] s;
    logic        co;
    logic [3:0]  fl;
  } vec_t;

  exp_t sbQ[$];
  exp_t monHead;
  int   nVectors = 0;
  int   nMiscompares = 0;

  vec_t vOvf, vSubEq, vNeg, vInc, vTmp;

  alu_flag_stage #(.W(32), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .f          (f),
    .s          (s),
    .c_out      (c_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_s      (out_s),
    .out_f      (out_f),
    .out_n      (out_n),
    .out_z      (out_z),
    .out_c      (out_c),
    .out_o      (out_o),
    .sticky_o   (sticky_o),
    .clr_sticky (clr_sticky),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(input logic [31:0] va, input logic [31:0] vb, input logic [3:0] vf,
                                 input logic [31:0] vs, input logic vco, input logic [3:0] vfl);
    vec_t v;
    v.a = va; v.b = vb; v.f = vf; v.s = vs; v.co = vco; v.fl = vfl;
    return v;
  endfunction

  // Plain non-overflowing additions: i*16 + 1, all flags clear
  function automatic vec_t seqVec(input int i);
    return mkVec(32'(i * 16), 32'h1, 4'b0000, 32'(i * 16 + 1), 1'b0, 4'b0000);
  endfunction

  task automatic driveInputs(input vec_t v);
    a = v.a; b = v.b; f = v.f; s = v.s; c_out = v.co;
    in_valid = 1'b1;
  endtask

  // Offers one vector and waits (bounded) for it to be accepted
  task automatic applyStimulus(input vec_t v);
    bit accepted = 1'b0;
    driveInputs(v);
    for (int k = 0; k < 20 && !accepted; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sbQ.push_back({v.s, v.f, v.fl});
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL accept_timeout: got no acceptance expected acceptance within 20 cycles");
    end
  endtask

  // Monitor: every handed-off head must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL pop_unexpected: got %h expected no entry", out_s);
      end else begin
        monHead = sbQ.pop_front();
        checkOutput("pop", 64'({out_s, out_f, out_n, out_z, out_c, out_o}), 64'(monHead));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vOvf   = mkVec(32'h7FFFFFFF, 32'h00000001, 4'b0000, 32'h80000000, 1'b0, 4'b1001);
    vSubEq = mkVec(32'h12345678, 32'h12345678, 4'b0001, 32'h00000000, 1'b1, 4'b0110);
    vNeg   = mkVec(32'hFFFFFFFF, 32'h80000000, 4'b0010, 32'h80000000, 1'b0, 4'b1001);
    vInc   = mkVec(32'h80000000, 32'hFFFFFFFF, 4'b1011, 32'h00000000, 1'b1, 4'b0110);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    a = '0; b = '0; f = '0; s = '0; c_out = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_in_ready",  64'(in_ready),  64'(1));
    checkOutput("rst_count",     64'(count),     64'(0));
    checkOutput("rst_sticky",    64'(sticky_o),  64'(0));
    checkOutput("rst_out_s",     64'(out_s),     64'(0));
    checkOutput("rst_out_f",     64'(out_f),     64'(0));
    checkOutput("rst_flags",     64'({out_n, out_z, out_c, out_o}), 64'(0));
    rst = 1'b0;

    // Flag vectors, sticky set and explicit clear
    out_ready = 1'b1;
    applyStimulus(vOvf);
    @(negedge clk);
    checkOutput("sticky_set", 64'(sticky_o), 64'(1));
    @(posedge clk); #1;
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    checkOutput("sticky_clr", 64'(sticky_o), 64'(0));
    applyStimulus(vSubEq);
    applyStimulus(vNeg);
    applyStimulus(vInc);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: third back-to-back push must be refused
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vTmp = seqVec(k);
      driveInputs(vTmp);
      @(negedge clk);
      if (k < 2) begin
        checkOutput("bp_ready", 64'(in_ready), 64'(1));
      end else begin
        checkOutput("bp_refuse", 64'(in_ready), 64'(0));
        checkOutput("bp_full",   64'(count),    64'(2));
      end
      if (in_ready) sbQ.push_back({vTmp.s, vTmp.f, vTmp.fl});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("bp_hold", 64'(out_s), 64'(32'h00000001));
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_drain1", 64'(count), 64'(1));
    @(posedge clk); #1;
    checkOutput("bp_drain0", 64'(count), 64'(0));

    // Simultaneous push and pop at count=1
    out_ready = 1'b0;
    applyStimulus(seqVec(10));
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vTmp = seqVec(11 + k);
      driveInputs(vTmp);
      @(negedge clk);
      checkOutput("pp_count", 64'(count), 64'(1));
      if (in_ready) sbQ.push_back({vTmp.s, vTmp.f, vTmp.fl});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("pp_empty", 64'(count), 64'(0));

    // Reset with a full buffer and sticky set
    out_ready = 1'b0;
    applyStimulus(vOvf);
    applyStimulus(vOvf);
    checkOutput("pre_rst_count",  64'(count),    64'(2));
    checkOutput("pre_rst_sticky", 64'(sticky_o), 64'(1));
    #2;
    sbQ.delete();
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid",  64'(out_valid), 64'(0));
    checkOutput("mid_rst_count",  64'(count),     64'(0));
    checkOutput("mid_rst_sticky", 64'(sticky_o),  64'(0));
    checkOutput("mid_rst_ready",  64'(in_ready),  64'(1));
    @(posedge clk); #1;
    rst = 1'b0;

    // Clear has priority over an overflowing push in the same cycle
    out_ready = 1'b1;
    clr_sticky = 1'b1;
    applyStimulus(vOvf);
    clr_sticky = 1'b0;
    checkOutput("clr_priority", 64'(sticky_o), 64'(0));

    for (int k = 0; k < 50 && sbQ.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    if (sbQ.size() != 0) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sbQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
